// File: rtl/false_color_pkg.sv
// false_color shared types and constants.
// Palette ids and the segment/offset split of the luminance byte.
package false_color_pkg;

    localparam int SEG_BITS = 2;
    localparam int OFF_BITS = 6;

    typedef enum logic [1:0] {
        MODE_GRAY  = 2'd0,
        MODE_HEAT  = 2'd1,
        MODE_JET   = 2'd2,
        MODE_SEPIA = 2'd3
    } mode_e;

endpackage

// File: rtl/false_color_if.sv
// Pixel stream bundle: luminance in, RGB out.
// master drives in_valid/in_Y; slave drives out_valid/out_R/G/B.
interface false_color_if;

    logic       in_valid;
    logic [7:0] in_Y;
    logic       out_valid;
    logic [7:0] out_R;
    logic [7:0] out_G;
    logic [7:0] out_B;

    modport master (
        output in_valid, in_Y,
        input  out_valid, out_R, out_G, out_B
    );

    modport slave (
        input  in_valid, in_Y,
        output out_valid, out_R, out_G, out_B
    );

endinterface

// File: rtl/false_color_lut.sv
// Combinational palette map (Y, mode) -> RGB.
// Ports: i_y luminance, i_mode palette, o_r/o_g/o_b colour.
module false_color_lut
    import false_color_pkg::*;
(
    input  logic [7:0] i_y,
    input  mode_e      i_mode,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b
);

    logic [SEG_BITS-1:0] w_seg;
    logic [OFF_BITS-1:0] w_off;
    logic [7:0]          w_r4;
    logic [6:0]          w_r2;
    logic [8:0]          w_sep_sum;

    assign w_seg     = i_y[7:6];
    assign w_off     = i_y[5:0];
    assign w_r4      = {w_off, 2'b00};
    assign w_r2      = {w_off, 1'b0};
    // Y + Y/8 may exceed 255; carry bit selects saturation.
    assign w_sep_sum = {1'b0, i_y} + {4'b0, i_y[7:3]};

    always_comb begin
        o_r = i_y;
        o_g = i_y;
        o_b = i_y;
        unique case (i_mode)
            MODE_GRAY: ;
            MODE_HEAT: begin
                unique case (w_seg)
                    2'd0: begin
                        o_r = w_r4; o_g = 8'd0; o_b = 8'd0;
                    end
                    2'd1: begin
                        o_r = 8'd255; o_g = w_r4; o_b = 8'd0;
                    end
                    2'd2: begin
                        o_r = 8'd255; o_g = 8'd255;
                        o_b = {1'b0, w_r2};
                    end
                    default: begin
                        o_r = 8'd255; o_g = 8'd255;
                        o_b = {1'b1, w_r2};
                    end
                endcase
            end
            MODE_JET: begin
                unique case (w_seg)
                    2'd0: begin
                        o_r = 8'd0; o_g = w_r4; o_b = 8'd255;
                    end
                    2'd1: begin
                        o_r = 8'd0; o_g = 8'd255;
                        o_b = 8'd255 - w_r4;
                    end
                    2'd2: begin
                        o_r = w_r4; o_g = 8'd255; o_b = 8'd0;
                    end
                    default: begin
                        o_r = 8'd255; o_g = 8'd255 - w_r4;
                        o_b = 8'd0;
                    end
                endcase
            end
            default: begin
                o_r = w_sep_sum[8] ? 8'd255 : w_sep_sum[7:0];
                o_g = i_y;
                o_b = i_y - {2'b00, i_y[7:2]};
            end
        endcase
    end

endmodule

// File: rtl/false_color.sv
// Two-stage gray -> false-colour expander with frame-latched config.
// Ports: clk, rst_n, enable/mode/frame_en config, px stream bundle.
module false_color
    import false_color_pkg::*;
#(
    parameter logic [1:0] RESET_MODE = 2'd0,
    parameter logic       RESET_EN   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic         frame_en,
    false_color_if.slave px
);

    logic       r_en_q;
    mode_e      r_mode_q;
    logic       r_v1;
    logic [7:0] r_y1;
    mode_e      r_m1;
    logic       r_v2;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;
    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q   <= RESET_EN;
            r_mode_q <= mode_e'(RESET_MODE);
        end else if (frame_en) begin
            r_en_q   <= enable;
            r_mode_q <= mode_e'(mode);
        end
    end

    // Pixel is tagged with the config in force before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_y1 <= 8'd0;
            r_m1 <= MODE_GRAY;
        end else begin
            r_v1 <= px.in_valid;
            if (px.in_valid) begin
                r_y1 <= px.in_Y;
                r_m1 <= r_en_q ? r_mode_q : MODE_GRAY;
            end
        end
    end

    false_color_lut u_lut (
        .i_y    (r_y1),
        .i_mode (r_m1),
        .o_r    (w_r),
        .o_g    (w_g),
        .o_b    (w_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_r  <= 8'd0;
            r_g  <= 8'd0;
            r_b  <= 8'd0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_r <= w_r;
                r_g <= w_g;
                r_b <= w_b;
            end
        end
    end

    assign px.out_valid = r_v2;
    assign px.out_R     = r_r;
    assign px.out_G     = r_g;
    assign px.out_B     = r_b;

endmodule

// File: tb/tb_false_color.sv
// Directed bench for false_color.
// Inputs change after negedge; outputs sampled at negedge.
module tb_false_color;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic       frame_en;
    int         n_cmp = 0;
    int         n_bad = 0;

    false_color_if px ();

    false_color #(
        .RESET_MODE (2'd0),
        .RESET_EN   (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .frame_en (frame_en),
        .px       (px)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input logic v,
                           input logic [7:0] r,
                           input logic [7:0] g,
                           input logic [7:0] b);
        check({tag, ".v"}, {31'b0, px.out_valid}, {31'b0, v});
        check({tag, ".rgb"},
              {8'b0, px.out_R, px.out_G, px.out_B},
              {8'b0, r, g, b});
    endtask

    task automatic cyc(input logic v, input logic [7:0] y,
                       input logic fe, input logic en,
                       input logic [1:0] md);
        px.in_valid = v;
        px.in_Y     = y;
        frame_en    = fe;
        enable      = en;
        mode        = md;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        px.in_valid = 1'b0;
        px.in_Y = 8'd0;
        enable = 1'b0;
        mode = 2'd0;
        frame_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_rgb("reset", 1'b0, 8'd0, 8'd0, 8'd0);
        rst_n = 1'b1;
        idle();

        // Config change coincides with pixel: old (gray) config.
        cyc(1'b1, 8'd100, 1'b1, 1'b1, 2'd1);
        cyc(1'b1, 8'd100, 1'b0, 1'b0, 2'd0);
        chk_rgb("cfg_old", 1'b1, 8'd100, 8'd100, 8'd100);
        idle();
        chk_rgb("cfg_new", 1'b1, 8'd255, 8'd144, 8'd0);

        // Jet
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 2'd2);
        cyc(1'b1, 8'd200, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'd0, 1'b0, 1'b0, 2'd0);
        chk_rgb("jet200", 1'b1, 8'd255, 8'd223, 8'd0);
        cyc(1'b1, 8'd64, 1'b0, 1'b0, 2'd0);
        chk_rgb("jet0", 1'b1, 8'd0, 8'd0, 8'd255);
        idle();
        chk_rgb("jet64", 1'b1, 8'd0, 8'd255, 8'd255);
        idle();
        chk_rgb("jet_hold", 1'b0, 8'd0, 8'd255, 8'd255);

        // Sepia
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 2'd3);
        cyc(1'b1, 8'd240, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'd16, 1'b0, 1'b0, 2'd0);
        chk_rgb("sep240", 1'b1, 8'd255, 8'd240, 8'd180);
        idle();
        chk_rgb("sep16", 1'b1, 8'd18, 8'd16, 8'd12);
        idle();

        // Mode switch while heat pixels are in flight
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 2'd1);
        cyc(1'b1, 8'd10, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'd20, 1'b1, 1'b1, 2'd2);
        chk_rgb("sw10", 1'b1, 8'd40, 8'd0, 8'd0);
        cyc(1'b1, 8'd30, 1'b0, 1'b0, 2'd0);
        chk_rgb("sw20", 1'b1, 8'd80, 8'd0, 8'd0);
        idle();
        chk_rgb("sw30", 1'b1, 8'd0, 8'd120, 8'd255);
        idle();

        // Gapped input (jet still active)
        cyc(1'b1, 8'd128, 1'b0, 1'b0, 2'd0);
        idle();
        chk_rgb("gap_a", 1'b1, 8'd0, 8'd255, 8'd0);
        cyc(1'b1, 8'd255, 1'b0, 1'b0, 2'd0);
        chk_rgb("gap_b", 1'b0, 8'd0, 8'd255, 8'd0);
        idle();
        chk_rgb("gap_c", 1'b1, 8'd255, 8'd3, 8'd0);
        idle();

        // Heat top endpoint
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 2'd1);
        cyc(1'b1, 8'd255, 1'b0, 1'b0, 2'd0);
        idle();
        chk_rgb("heat255", 1'b1, 8'd255, 8'd255, 8'd254);
        cyc(1'b1, 8'd192, 1'b0, 1'b0, 2'd0);
        idle();
        chk_rgb("heat192", 1'b1, 8'd255, 8'd255, 8'd128);

        // Disabled: gray in every mode
        for (int m = 0; m < 4; m++) begin
            cyc(1'b0, 8'd0, 1'b1, 1'b0, 2'(m));
            cyc(1'b1, 8'd77, 1'b0, 1'b0, 2'd0);
            idle();
            chk_rgb($sformatf("dis%0d", m), 1'b1,
                    8'd77, 8'd77, 8'd77);
        end

        // Async reset mid-burst, re-enable sepia first
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 2'd3);
        cyc(1'b1, 8'd50, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'd60, 1'b0, 1'b0, 2'd0);
        chk_rgb("pre_rst", 1'b1, 8'd56, 8'd50, 8'd38);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rgb("async_rst", 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        px.in_valid = 1'b0;
        idle();
        chk_rgb("post_rst", 1'b0, 8'd0, 8'd0, 8'd0);
        cyc(1'b1, 8'd90, 1'b0, 1'b0, 2'd0);
        chk_rgb("lat1", 1'b0, 8'd0, 8'd0, 8'd0);
        idle();
        chk_rgb("lat2", 1'b1, 8'd90, 8'd90, 8'd90);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/false_color.md
Name: false_color

Overview:
- Inverse-direction companion to the luminance stage: takes an 8-bit gray/luminance pixel stream and expands it back to 24-bit RGB through a selectable palette (gray, heat, jet, sepia).
- Sits after the grayscale path in the D8M video pipeline.
- Mode and enable update only at frame boundaries. Pixels already in flight keep the mode they were tagged with on entry.

Parameters:
- RESET_MODE, 2'd0, palette selected after reset.
- RESET_EN, 1'b0, enable state after reset.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  requested palette enable; sampled only when frame_en=1
- mode  input  2  requested palette; sampled only when frame_en=1 (0 gray, 1 heat, 2 jet, 3 sepia)
- frame_en  input  1  one-cycle frame-boundary strobe
- in_valid  input  1  in_Y qualifier
- in_Y  input  8  luminance pixel
- out_valid  output  1  out_R/G/B qualifier
- out_R  output  8  red
- out_G  output  8  green
- out_B  output  8  blue

Behaviour:
- Reset (rst_n=0, async):
  - en_q=RESET_EN, mode_q=RESET_MODE.
  - All pipeline valid bits 0; out_valid=0; out_R/G/B=0.
  - Reset mid-frame drops all in-flight pixels. No output until new input arrives.
- Config registers:
  - On a clk edge with frame_en=1: en_q<=enable, mode_q<=mode.
  - Otherwise en_q and mode_q hold their values.
- Stage 1 (capture):
  - Every edge: v1<=in_valid.
  - If in_valid: y1<=in_Y, m1<=(en_q ? mode_q : 0). This is the pre-update value when frame_en and in_valid coincide.
  - If frame_en and in_valid are 1 in the same cycle, that pixel uses the OLD config; the first pixel after the edge uses the new one.
- Stage 2 (map):
  - Every edge: out_valid<=v1.
  - If v1: out_R/G/B<=palette(y1, m1).
  - When v1=0, outputs hold their last value.
- Latency: exactly 2 clk from in_valid to out_valid.
- Throughput: 1 pixel/clk. No backpressure. Gaps in in_valid propagate unchanged.
- Palette definitions (seg=Y[7:6], off=Y[5:0], r4={off,2'b00}, r2={off,1'b0}):
  - Gray (0): R=G=B=Y.
  - Heat (1):
    - seg0: R=r4, G=0, B=0
    - seg1: R=255, G=r4, B=0
    - seg2: R=255, G=255, B=r2
    - seg3: R=255, G=255, B=128+r2
  - Jet (2):
    - seg0: R=0, G=r4, B=255
    - seg1: R=0, G=255, B=255-r4
    - seg2: R=r4, G=255, B=0
    - seg3: R=255, G=255-r4, B=0
  - Sepia (3):
    - R=min(255, Y+(Y>>3)), computed as a 9-bit sum then saturated.
    - G=Y.
    - B=Y-(Y>>2), which cannot underflow.
- Width rules:
  - All intermediates are at most 9 bits; no result is truncated silently.
  - Segment endpoints: heat Y=255 gives (255,255,254); jet Y=0 gives (0,0,255).

Decomposition:
- Package false_color_pkg: MODE_GRAY/HEAT/JET/SEPIA constants, SEG_BITS=2, OFF_BITS=6.
- Sub-module false_color_lut: combinational (y, mode) -> {R,G,B}. It is instantiated between stage 1 and stage 2, which keeps the top module to the config and pipeline registers.

Test Plan:
- Reset with RESET_EN=0, then in_Y=100 valid and a frame_en carrying enable=1, mode=1 in the same cycle -> 2 clk later out=(100,100,100). Next pixel in_Y=100 -> (255,144,0).
- Jet active, in_Y=200 -> (255,223,0). in_Y=0 -> (0,0,255). in_Y=64 -> (0,255,255).
- Sepia active, in_Y=240 -> (255,240,180). in_Y=16 -> (18,16,12).
- Mode switch mid-stream: heat pixels Y=10,20 in flight, frame_en with mode=2 on the Y=20 cycle -> outputs (40,0,0), (80,0,0), then the following Y=30 -> (0,120,255).
- Gapped input: in_valid=1,0,1 -> out_valid=1,0,1 two cycles later; outputs hold during the gap. enable=0 latched -> gray passthrough in every mode.
- rst_n asserted async mid-burst -> out_valid=0 and outputs 0 immediately with no clock. After release, the first output appears exactly 2 clk after the next in_valid.
